// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter with start bit, LSB-first data, optional second stop bit.
// Parity state and logic are built only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic                        i_Tx_DV,
  input  logic [DATA_BITS-1:0]        i_Tx_Byte,
  input  logic [DIV_WIDTH-1:0]        i_Clks_Per_Bit,
  input  logic                        i_Stop2,
  input  logic                        i_Parity_En,
  input  logic                        i_Parity_Odd,
  output logic                        o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
  output logic                        o_Tx_Serial,
  output logic                        o_Tx_Active,
  output logic                        o_Tx_Done,
  output logic                        o_Overflow
);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DIV_WIDTH-1:0] clk_cnt_q, clk_cnt_d, div_q, div_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 stop2_q, stop2_d;
  logic                 overflow_q;
  logic                 full, push, load, bit_last, serial, done;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d, par_bit_q, par_bit_d;
`else
  logic unused_par;
  assign unused_par = i_Parity_En ^ i_Parity_Odd;
`endif

  // Room is judged on the pre-edge count, so a same-cycle pop never admits a write.
  assign full     = (count_q == FullCnt);
  assign push     = i_Tx_DV && !full;
  assign bit_last = (clk_cnt_q == div_q - DIV_WIDTH'(1));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    clk_cnt_d = clk_cnt_q + DIV_WIDTH'(1);
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    stop2_d   = stop2_q;
    load      = 1'b0;
    serial    = 1'b1;
    done      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        if (count_q != '0) load = 1'b1;
      end
      StStart: begin
        serial = 1'b0;
        if (bit_last) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        serial = shift_q[0];
        if (bit_last) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = par_en_q ? StParity : StStop;
`else
            state_d   = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        serial = par_bit_q;
        if (bit_last) begin
          clk_cnt_d = '0;
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (bit_last) begin
          clk_cnt_d = '0;
          // bit_cnt doubles as the stop-bit index.
          if (stop2_q && bit_cnt_q == '0) begin
            bit_cnt_d = BitW'(1);
          end else begin
            done = 1'b1;
            if (count_q != '0) load = 1'b1;
            else state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Pop the head and freeze the line settings for the whole next frame.
    if (load) begin
      shift_d   = mem_q[rd_ptr_q];
      div_d     = (i_Clks_Per_Bit == '0) ? DIV_WIDTH'(1) : i_Clks_Per_Bit;
      stop2_d   = i_Stop2;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      state_d   = StStart;
`ifdef UART_TX_PARITY_EN
      par_en_d  = i_Parity_En;
      par_bit_d = (^mem_q[rd_ptr_q]) ^ i_Parity_Odd;
`endif
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      clk_cnt_q  <= '0;
      div_q      <= DIV_WIDTH'(1);
      bit_cnt_q  <= '0;
      stop2_q    <= 1'b0;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      clk_cnt_q  <= clk_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      stop2_q    <= stop2_d;
      overflow_q <= i_Tx_DV && full;
      count_q    <= count_q + CntW'(push) - CntW'(load);
      if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (load) rd_ptr_q <= rd_ptr_q + AddrW'(1);
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push && !i_Reset) mem_q[wr_ptr_q] <= i_Tx_Byte;
  end

  assign o_Tx_Ready   = !full;
  assign o_Fifo_Count = count_q;
  assign o_Tx_Serial  = serial | i_Reset;
  assign o_Tx_Active  = (state_q != StIdle) && !i_Reset;
  assign o_Tx_Done    = done && !i_Reset;
  assign o_Overflow   = overflow_q;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame, legal 5..8.
REQ-002 Parameter FIFO_DEPTH, default 16, transmit FIFO entries, power of two, legal 2..256.
REQ-003 Parameter DIV_WIDTH, default 16, width of the baud divisor input.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 i_Clock  in  1  sole clock, all logic on rising edge.
REQ-006 i_Reset  in  1  synchronous active-high reset.
REQ-007 i_Tx_DV  in  1  write strobe, one byte per cycle high.
REQ-008 i_Tx_Byte  in  DATA_BITS  byte to enqueue, LSB sent first.
REQ-009 i_Clks_Per_Bit  in  DIV_WIDTH  clocks per bit; 0 treated as 1.
REQ-010 i_Stop2  in  1  1 = two stop bits, 0 = one.
REQ-011 i_Parity_En  in  1  parity bit enable (see REQ-030).
REQ-012 i_Parity_Odd  in  1  1 = odd parity, 0 = even.
REQ-013 o_Tx_Ready  out  1  FIFO not full.
REQ-014 o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  entries queued, excluding the frame in flight.
REQ-015 o_Tx_Serial  out  1  serial line, idle high.
REQ-016 o_Tx_Active  out  1  frame in progress.
REQ-017 o_Tx_Done  out  1  one-cycle pulse per completed frame.
REQ-018 o_Overflow  out  1  one-cycle pulse when i_Tx_DV is high while full.

Function
REQ-019 Writes SHALL be accepted iff i_Tx_DV=1 and o_Tx_Ready=1 at that edge; a write while full SHALL be dropped and SHALL pulse o_Overflow; a simultaneous pop never frees room for a same-cycle write.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; undefined encodings SHALL return to IDLE.
REQ-021 IDLE: line high; if FIFO non-empty, pop the head, latch divisor, i_Stop2, i_Parity_En and i_Parity_Odd, then enter START; config changes mid-frame SHALL have no effect until the next frame.
REQ-022 A byte written at edge E0 into an empty FIFO while IDLE SHALL drive the start bit (0) from edge E0+1, with o_Tx_Active high from E0+1.
REQ-023 Each bit SHALL last exactly max(i_Clks_Per_Bit,1) cycles; order: start, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits (1).
REQ-024 Frame length SHALL be (1+DATA_BITS+P+S)*divisor cycles, P in {0,1}, S in {1,2}.
REQ-025 Parity bit SHALL be XOR of the data bits for even, inverted for odd.
REQ-026 At the last stop-bit cycle, o_Tx_Done SHALL pulse for one cycle; if the FIFO is non-empty, the next start bit SHALL begin on the following edge with no idle gap and o_Tx_Active held high; otherwise o_Tx_Active drops and the FSM returns to IDLE.
REQ-027 Bit counter and divisor counter SHALL be wide enough for DIV_WIDTH and DATA_BITS without wrap; FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 Reset SHALL force o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Overflow=0, o_Fifo_Count=0, o_Tx_Ready=1, FSM=IDLE, and empty the FIFO.
REQ-029 Reset mid-frame SHALL abort the frame immediately (line high on the next cycle) with no o_Tx_Done pulse; i_Tx_DV during reset SHALL be ignored.

Configuration
REQ-030 Macro UART_TX_PARITY_EN: defined -> PARITY state and parity logic built, i_Parity_En/i_Parity_Odd honoured; undefined -> no parity logic, both inputs ignored, P=0 always.

Verification
REQ-031 8N1, divisor 4, write 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 each 4 cycles, o_Tx_Done pulse at cycle 40, o_Tx_Active high cycles 1..40.
REQ-032 Macro defined, 8E1 and 8O1, divisor 2, byte 0x07 -> parity bit 1 (even) and 0 (odd), frames 22 cycles.
REQ-033 FIFO_DEPTH 4, divisor 8, five back-to-back writes 0x01..0x05 -> first popped, four queued, none dropped, five contiguous frames with no idle gap.
REQ-034 FIFO_DEPTH 4, divisor 100, six writes in six cycles -> fifth write accepted, sixth drops with one o_Overflow pulse, o_Tx_Ready low while count=4.
REQ-035 DATA_BITS 5, i_Stop2=1, divisor 0 -> 1-cycle bits, 8-cycle frame ending with two high stop bits.
REQ-036 Reset at cycle 10 of a divisor-4 frame with 3 queued -> line high next cycle, count 0, no o_Tx_Done; next write transmits normally.
